// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid_mover sliding-tile engine.
// Cell (r,c) lives at bits [(r*4+c)*4 +: 4] of a 64-bit board.
package grid_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SLIDE = 2'd1,
        S_SPAWN = 2'd2,
        S_CHECK = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef logic [3:0]      cell_t;
    typedef logic [3:0][3:0] line_t;

    localparam cell_t WIN_EXP = 4'd11;
    localparam cell_t MAX_EXP = 4'd15;

    function automatic logic [3:0] cell_idx(
        input logic [1:0] r,
        input logic [1:0] c
    );
        return {r, c};
    endfunction

    // Element 0 of a line is the cell nearest the move direction.
    function automatic logic [3:0] line_cell(
        input dir_e       dir,
        input logic [1:0] line,
        input logic [1:0] elem
    );
        logic [3:0] idx;
        unique case (dir)
            DIR_LEFT:  idx = cell_idx(line, elem);
            DIR_RIGHT: idx = cell_idx(line, ~elem);
            DIR_UP:    idx = cell_idx(elem, line);
            default:   idx = cell_idx(~elem, line);
        endcase
        return idx;
    endfunction

    function automatic cell_t get_cell(
        input logic [63:0] g,
        input logic [3:0]  idx
    );
        return g[{idx, 2'b00} +: 4];
    endfunction

    function automatic cell_t sat_inc(input cell_t c);
        return (c == MAX_EXP) ? MAX_EXP : c + 4'd1;
    endfunction

    function automatic logic has_exp(
        input logic [63:0] g,
        input cell_t       v
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (get_cell(g, 4'(i)) == v) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when the board is full and no orthogonal pair can merge.
    function automatic logic stuck(input logic [63:0] g);
        logic  s;
        cell_t a;
        s = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a = get_cell(g, cell_idx(2'(r), 2'(c)));
                if (a == '0) s = 1'b0;
                if (c < 3 && a == get_cell(g, cell_idx(2'(r), 2'(c + 1))))
                    s = 1'b0;
                if (r < 3 && a == get_cell(g, cell_idx(2'(r + 1), 2'(c))))
                    s = 1'b0;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational compact-and-merge of one 4-cell line toward element 0.
// Each tile merges at most once; merged exponents saturate at 15.
module line_merge
    import grid_pkg::*;
(
    input  line_t line_in,
    output line_t line_out,
    output logic  changed
);

    cell_t      cmp [5];
    logic [2:0] k;
    logic [2:0] j;
    logic       skip;

    // Pack non-zero tiles toward element 0, then merge pairs outward.
    always_comb begin
        for (int i = 0; i < 5; i++) cmp[i] = '0;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            if (line_in[i] != '0) begin
                cmp[k] = line_in[i];
                k = k + 3'd1;
            end
        end
        line_out = '0;
        j = '0;
        skip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[i] != '0) begin
                if (cmp[i] == cmp[i + 1]) begin
                    line_out[j[1:0]] = sat_inc(cmp[i]);
                    skip = 1'b1;
                end else begin
                    line_out[j[1:0]] = cmp[i];
                end
                j = j + 3'd1;
            end
        end
        changed = (line_out != line_in);
    end

endmodule

// File: rtl/grid_mover.sv
// 4x4 sliding-tile board engine: one line per cycle, spawn, end check.
// Optional SPAWN_FOUR_EN: every tenth spawn places exponent 2.
module grid_mover
    import grid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] grid_in,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic [3:0]  lfsr_out,
    output logic [63:0] grid,
    output logic        done,
    output logic        moved,
    output logic        win,
    output logic        game_over
);

    state_e      state;
    state_e      state_n;
    dir_e        dir_q;
    logic [1:0]  line_q;
    logic        chg_q;
    line_t       line_in;
    line_t       line_out;
    logic        line_chg;
    logic [63:0] grid_slid;
    logic [63:0] grid_spawn;
    logic        any_empty;
    logic        spawn_hit;
    cell_t       spawn_val;

    line_merge u_line (
        .line_in  (line_in),
        .line_out (line_out),
        .changed  (line_chg)
    );

    // Gather the current line from the board, nearest cell first.
    always_comb begin
        for (int e = 0; e < 4; e++) begin
            line_in[e] = get_cell(grid, line_cell(dir_q, line_q, 2'(e)));
        end
    end

    // Scatter the merged line back and build the spawn candidate board.
    always_comb begin
        grid_slid = grid;
        for (int e = 0; e < 4; e++) begin
            grid_slid[{line_cell(dir_q, line_q, 2'(e)), 2'b00} +: 4] =
                line_out[e];
        end
        grid_spawn = grid;
        grid_spawn[{lfsr_out, 2'b00} +: 4] = spawn_val;
        any_empty = has_exp(grid, '0);
        spawn_hit = (get_cell(grid, lfsr_out) == '0);
    end

`ifdef SPAWN_FOUR_EN
    logic [3:0] spawn_cnt;

    assign spawn_val = (spawn_cnt == 4'd9) ? 4'd2 : 4'd1;

    // Count placed tiles modulo ten to pick the occasional bigger tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawn_cnt <= '0;
        end else if (state == S_SPAWN && any_empty && spawn_hit) begin
            spawn_cnt <= (spawn_cnt == 4'd9) ? 4'd0 : spawn_cnt + 4'd1;
        end
    end
`else
    assign spawn_val = 4'd1;
`endif

    assign move_ready = (state == S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state selection; load wins over a move request in IDLE.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (!load && move_valid) state_n = S_SLIDE;
            end
            S_SLIDE: begin
                if (line_q == 2'd3)
                    state_n = (chg_q || line_chg) ? S_SPAWN : S_CHECK;
            end
            S_SPAWN: begin
                if (!any_empty || spawn_hit) state_n = S_CHECK;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Board, move bookkeeping and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid      <= '0;
            dir_q     <= DIR_LEFT;
            line_q    <= '0;
            chg_q     <= 1'b0;
            done      <= 1'b0;
            moved     <= 1'b0;
            win       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        grid      <= grid_in;
                        win       <= 1'b0;
                        game_over <= 1'b0;
                    end else if (move_valid) begin
                        dir_q  <= dir_e'(move_dir);
                        line_q <= '0;
                        chg_q  <= 1'b0;
                    end
                end
                S_SLIDE: begin
                    grid   <= grid_slid;
                    chg_q  <= chg_q | line_chg;
                    line_q <= line_q + 2'd1;
                    win    <= win | has_exp(grid_slid, WIN_EXP);
                end
                S_SPAWN: begin
                    if (any_empty && spawn_hit) begin
                        grid <= grid_spawn;
                        win  <= win | has_exp(grid_spawn, WIN_EXP);
                    end
                end
                default: begin
                    done      <= 1'b1;
                    moved     <= chg_q;
                    game_over <= game_over | stuck(grid);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_mover.sv
// Scoreboard bench for grid_mover: a queue-based line model predicts
// each move; a monitor compares on every done pulse.
module tb_grid_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [63:0] grid_in;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic [3:0]  lfsr_out;
    logic [63:0] grid;
    logic        done;
    logic        moved;
    logic        win;
    logic        game_over;

    grid_mover dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .grid_in    (grid_in),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .lfsr_out   (lfsr_out),
        .grid       (grid),
        .done       (done),
        .moved      (moved),
        .win        (win),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] g;
        bit          mv;
        bit          w;
        bit          go;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    logic [63:0] m_board = '0;
    bit          m_win   = 0;
    bit          m_over  = 0;
    int          m_cnt   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] getc(logic [63:0] g, int r, int c);
        return g[(r * 4 + c) * 4 +: 4];
    endfunction

    function automatic logic [63:0] setc(logic [63:0] g, int r, int c,
                                         int v);
        g[(r * 4 + c) * 4 +: 4] = 4'(v);
        return g;
    endfunction

    // Reference: walk each line from the leading edge, merge via queues.
    function automatic void model_slide(input logic [63:0] g, input int dir,
                                        output logic [63:0] out,
                                        output bit chg);
        out = g;
        for (int ln = 0; ln < 4; ln++) begin
            int rr[4];
            int cc[4];
            int tiles[$];
            int res[$];
            for (int k = 0; k < 4; k++) begin
                case (dir)
                    0:       begin rr[k] = ln;    cc[k] = k;     end
                    1:       begin rr[k] = ln;    cc[k] = 3 - k; end
                    2:       begin rr[k] = k;     cc[k] = ln;    end
                    default: begin rr[k] = 3 - k; cc[k] = ln;    end
                endcase
                if (getc(g, rr[k], cc[k]) != 0)
                    tiles.push_back(int'(getc(g, rr[k], cc[k])));
            end
            while (tiles.size() > 0) begin
                int a;
                a = tiles.pop_front();
                if (tiles.size() > 0 && tiles[0] == a) begin
                    void'(tiles.pop_front());
                    res.push_back(a == 15 ? 15 : a + 1);
                end else begin
                    res.push_back(a);
                end
            end
            while (res.size() < 4) res.push_back(0);
            for (int k = 0; k < 4; k++) out = setc(out, rr[k], cc[k], res[k]);
        end
        chg = (out != g);
    endfunction

    function automatic bit model_stuck(logic [63:0] g);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (getc(g, r, c) == 0) return 0;
                if (c < 3 && getc(g, r, c) == getc(g, r, c + 1)) return 0;
                if (r < 3 && getc(g, r, c) == getc(g, r + 1, c)) return 0;
            end
        end
        return 1;
    endfunction

    function automatic bit model_has11(logic [63:0] g);
        for (int i = 0; i < 16; i++) if (g[i * 4 +: 4] == 4'd11) return 1;
        return 0;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d moves pending, expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic do_load(logic [63:0] board, bit with_move);
        @(negedge clk);
        load = 1'b1;
        grid_in = board;
        move_valid = with_move;
        move_dir = 2'(($urandom_range(0, 3)));
        @(posedge clk);
        #1;
        load = 1'b0;
        move_valid = 1'b0;
        m_board = board;
        m_win = 0;
        m_over = 0;
        check("load_grid", grid, board);
        check("load_win", win, 0);
        check("load_over", game_over, 0);
        check("load_ready", move_ready, 1);
    endtask

    task automatic do_move(int dir, int retries, bit junk);
        logic [63:0] slid;
        logic [63:0] fin;
        bit          chg;
        int          tgt;
        int          occ;
        int          v;
        int          empt[$];
        int          full[$];
        exp_t        e;
        model_slide(m_board, dir, slid, chg);
        fin = slid;
        tgt = $urandom_range(0, 15);
        occ = tgt;
        if (chg) begin
            for (int i = 0; i < 16; i++) begin
                if (slid[i * 4 +: 4] == 0) empt.push_back(i);
                else full.push_back(i);
            end
            if (empt.size() > 0) begin
                tgt = empt[$urandom_range(0, empt.size() - 1)];
                if (full.size() > 0)
                    occ = full[$urandom_range(0, full.size() - 1)];
                else retries = 0;
                v = 1;
`ifdef SPAWN_FOUR_EN
                v = (m_cnt == 9) ? 2 : 1;
                m_cnt = (m_cnt + 1) % 10;
`endif
                fin[tgt * 4 +: 4] = 4'(v);
            end else begin
                retries = 0;
            end
        end else begin
            retries = 0;
        end
        m_win = m_win | model_has11(fin);
        m_over = m_over | model_stuck(fin);
        m_board = fin;
        @(negedge clk);
        move_valid = 1'b1;
        move_dir = 2'(dir);
        lfsr_out = (retries > 0) ? 4'(occ) : 4'(tgt);
        @(posedge clk);
        #1;
        e.g = fin;
        e.mv = chg;
        e.w = m_win;
        e.go = m_over;
        e.lat = chg ? 6 + retries : 5;
        e.acc = cyc;
        sb.push_back(e);
        if (junk) begin
            load = 1'b1;
            grid_in = {$urandom, $urandom};
        end else begin
            move_valid = 1'b0;
        end
        for (int k = 1; k <= 4 + retries; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                move_valid = 1'b0;
                load = 1'b0;
            end
            if (k == 4 + retries) lfsr_out = 4'(tgt);
        end
        wait_idle();
    endtask

    exp_t mon_e;
    bit   prev_done = 0;

    // Monitor: pop one prediction per done pulse and compare.
    always @(negedge clk) begin
        if (prev_done) check("done_pulse", done, 0);
        prev_done = done;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                mon_e = sb.pop_front();
                check("grid", grid, mon_e.g);
                check("moved", moved, mon_e.mv);
                check("win", win, mon_e.w);
                check("game_over", game_over, mon_e.go);
                check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                check("ready_at_done", move_ready, 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] b;

    initial begin
        rst = 1'b1;
        load = 1'b0;
        grid_in = '0;
        move_valid = 1'b0;
        move_dir = '0;
        lfsr_out = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grid", grid, 0);
        check("rst_done", done, 0);
        check("rst_moved", moved, 0);
        check("rst_win", win, 0);
        check("rst_over", game_over, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", move_ready, 1);

        b = '0;
        for (int c = 0; c < 4; c++) b = setc(b, 0, c, 1);
        do_load(b, 1);
        do_move(0, 0, 0);
        check("row0_1111_left", grid[7:0], 8'h22);

        b = setc(setc(64'h0, 0, 0, 1), 0, 3, 1);
        do_load(b, 0);
        do_move(1, 0, 0);
        check("row0_1001_right", grid[15:0] & 16'hF000, 16'h2000);

        b = setc(setc(setc(64'h0, 0, 0, 3), 1, 0, 3), 2, 0, 3);
        do_load(b, 0);
        do_move(2, 0, 0);
        check("col_333_up_c0", getc(grid, 0, 0), 4);
        check("col_333_up_c1", getc(grid, 1, 0), 3);

        do_load(setc(64'h0, 0, 0, 1), 0);
        do_move(0, 0, 0);

        do_load(setc(setc(64'h0, 0, 0, 10), 0, 1, 10), 0);
        do_move(0, 0, 0);
        check("win_cell0", getc(grid, 0, 0), 11);
        for (int i = 0; i < 3; i++) do_move($urandom_range(0, 3), 1, 1);
        check("win_sticky", win, 1);
        do_load(64'h0000_0000_0000_0011, 0);

        do_load(setc(setc(64'h0, 1, 0, 15), 1, 1, 15), 0);
        do_move(0, 0, 0);
        check("sat_15", getc(grid, 1, 0), 15);

        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b = setc(b, r, c, ((r + c) % 2) ? 1 : 2);
        do_load(b, 0);
        do_move(2, 0, 0);
        check("stuck_over", game_over, 1);

        do_load(setc(setc(64'h0, 2, 0, 1), 2, 1, 1), 0);
        do_move(0, 3, 1);

        b = '0;
        for (int c = 0; c < 4; c++) b = setc(b, 0, c, 1);
        do_load(b, 0);
        @(negedge clk);
        move_valid = 1'b1;
        move_dir = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("slide_line0", grid[15:0], 16'h0022);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_grid", grid, 0);
        check("midrst_ready", move_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_moved", moved, 0);
        check("midrst_win", win, 0);
        move_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_board = '0;
        m_win = 0;
        m_over = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        check("midrst_ready_after", move_ready, 1);
        check("midrst_grid_after", grid, 0);

        for (int rnd = 0; rnd < 6; rnd++) begin
            b = '0;
            for (int i = 0; i < 16; i++)
                b[i * 4 +: 4] = 4'($urandom_range(0, 3));
            do_load(b, $urandom_range(0, 1));
            for (int m = 0; m < 8; m++)
                do_move($urandom_range(0, 3), $urandom_range(0, 2),
                        $urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
